mem_stage: RTL and testbench



---
 rtl/rv_pkg.sv | 54 +++++
 rtl/load_align.sv | 34 +++
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I load/store definitions for the memory stage
//
// Holds the funct3 access encodings, the LSU state enum, the EX/MEM pipeline
// register layout and the access-legality check used at accept time.

package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_state_t;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exmem_t;

    // True when a memory access cannot be issued: conflicting load/store,
    // an encoding the access kind does not define, or a misaligned address.
    // funct3[1:0] carries the size for both loads and stores.
    function automatic logic lsu_fault(
        input logic       is_load,
        input logic       is_store,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic bad;
        bad = is_load && is_store;
        if (is_load && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
            bad = 1'b1;
        if (is_store && !(f3 inside {F3_B, F3_H, F3_W}))
            bad = 1'b1;
        if (f3[1:0] == 2'b01 && a[0])
            bad = 1'b1;
        if (f3[1:0] == 2'b10 && a != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select and sign/zero extension
//
// Ports:
//   rdata  in  32  raw data word from memory
//   addr   in  2   byte offset of the access within the word
//   funct3 in  3   load size/sign encoding
//   data   out 32  extended result for writeback

module load_align
    import rv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] lane;

    // Bring the addressed byte/halfword down to bit 0.
    assign lane = rdata >> {addr, 3'b000};

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   data = {24'h0, lane[7:0]};
            F3_HU:   data = {16'h0, lane[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM register and single-outstanding data-memory access
//
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   valid_i, alu_result_i, w_ram_data_i,  instruction from Execute
//   mem_read_i, mem_write_i, funct3_i,
//   rd_i, reg_write_i
//   stall_o                               upstream hold
//   dmem_req_o/we_o/addr_o/be_o/wdata_o   data-memory request
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
//   wb_valid_o/rd_o/reg_write_o/data_o    one-cycle writeback pulse
//   lsu_fault_o                           fault flag alongside wb_valid_o
//   fwd_rd_o/reg_write_o/data_o           EX/MEM contents for forwarding

module mem_stage
    import rv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] w_ram_data_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_reg_write_o,
    output logic [31:0] wb_data_o,
    output logic        lsu_fault_o,
    output logic [4:0]  fwd_rd_o,
    output logic        fwd_reg_write_o,
    output logic [31:0] fwd_data_o
);

    lsu_state_t  state;
    lsu_state_t  state_next;
    exmem_t      ex;
    logic        accept;
    logic        is_mem;
    logic        fault_in;
    logic        mem_live;
    logic [31:0] load_data;

    assign accept   = valid_i && (state == IDLE);
    assign is_mem   = mem_read_i || mem_write_i;
    assign fault_in = is_mem && lsu_fault(mem_read_i, mem_write_i, funct3_i, alu_result_i[1:0]);
    assign stall_o  = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dmem_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_mem && !fault_in)
                    state_next = REQ;
            end
            REQ: begin
                dmem_req_o = 1'b1;
                if (dmem_gnt_i)
                    state_next = ex.mem_write ? IDLE : WAIT;
            end
            WAIT: begin
                if (dmem_rvalid_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The register empties into a bubble whenever IDLE sees no new instruction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex <= '0;
        end else if (accept) begin
            ex <= '{valid:     1'b1,
                    fault:     fault_in,
                    mem_read:  mem_read_i,
                    mem_write: mem_write_i,
                    reg_write: reg_write_i,
                    funct3:    funct3_i,
                    rd:        rd_i,
                    addr:      alu_result_i,
                    wdata:     w_ram_data_i};
        end else if (state == IDLE) begin
            ex.valid <= 1'b0;
        end
    end

    load_align u_load_align (
        .rdata  (dmem_rdata_i),
        .addr   (ex.addr[1:0]),
        .funct3 (ex.funct3),
        .data   (load_data)
    );

    // ALU ops and faults write back off the accept edge; memory ops off the
    // edge that completes the bus transaction. The FSM keeps these exclusive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_o     <= 1'b0;
            wb_rd_o        <= '0;
            wb_reg_write_o <= 1'b0;
            wb_data_o      <= '0;
            lsu_fault_o    <= 1'b0;
        end else begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            lsu_fault_o    <= 1'b0;
            if (accept && (!is_mem || fault_in)) begin
                wb_valid_o     <= 1'b1;
                wb_rd_o        <= rd_i;
                wb_data_o      <= alu_result_i;
                wb_reg_write_o <= reg_write_i && !fault_in;
                lsu_fault_o    <= fault_in;
            end else if (state == REQ && dmem_gnt_i && ex.mem_write) begin
                wb_valid_o     <= 1'b1;
                wb_rd_o        <= ex.rd;
                wb_data_o      <= ex.addr;
            end else if (state == WAIT && dmem_rvalid_i) begin
                wb_valid_o     <= 1'b1;
                wb_rd_o        <= ex.rd;
                wb_data_o      <= load_data;
                wb_reg_write_o <= ex.reg_write;
            end
        end
    end

    assign mem_live = ex.valid && !ex.fault && (ex.mem_read || ex.mem_write);

    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = ex.wdata;
        case (ex.funct3[1:0])
            2'b00: begin
                dmem_be_o    = 4'b0001 << ex.addr[1:0];
                dmem_wdata_o = {4{ex.wdata[7:0]}};
            end
            2'b01: begin
                dmem_be_o    = 4'b0011 << ex.addr[1:0];
                dmem_wdata_o = {2{ex.wdata[15:0]}};
            end
            default: dmem_be_o = 4'b1111;
        endcase
        if (!mem_live)
            dmem_be_o = 4'b0000;
    end

    assign dmem_we_o   = mem_live && ex.mem_write;
    assign dmem_addr_o = {ex.addr[31:2], 2'b00};

    assign fwd_rd_o        = ex.rd;
    assign fwd_reg_write_o = ex.valid && !ex.fault && ex.reg_write;
    assign fwd_data_o      = ex.addr;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage

module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] w_ram_data_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        reg_write_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic        wb_reg_write_o;
    logic [31:0] wb_data_o;
    logic        lsu_fault_o;
    logic [4:0]  fwd_rd_o;
    logic        fwd_reg_write_o;
    logic [31:0] fwd_data_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    mem_stage dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .valid_i         (valid_i),
        .alu_result_i    (alu_result_i),
        .w_ram_data_i    (w_ram_data_i),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .funct3_i        (funct3_i),
        .rd_i            (rd_i),
        .reg_write_i     (reg_write_i),
        .stall_o         (stall_o),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_gnt_i      (dmem_gnt_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .wb_valid_o      (wb_valid_o),
        .wb_rd_o         (wb_rd_o),
        .wb_reg_write_o  (wb_reg_write_o),
        .wb_data_o       (wb_data_o),
        .lsu_fault_o     (lsu_fault_o),
        .fwd_rd_o        (fwd_rd_o),
        .fwd_reg_write_o (fwd_reg_write_o),
        .fwd_data_o      (fwd_data_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw);
        valid_i      = 1'b1;
        mem_read_i   = rd_en;
        mem_write_i  = wr_en;
        funct3_i     = f3;
        alu_result_i = addr;
        w_ram_data_i = wd;
        rd_i         = rd;
        reg_write_i  = rw;
    endtask

    task automatic idle_inputs();
        valid_i     = 1'b0;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    // Load with gnt and rvalid held high from the accept cycle: rvalid seen
    // in IDLE/REQ must be ignored, so the result lands exactly 3 cycles later.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        int lat;
        lat = 0;
        @(negedge clk_i);
        drive(1'b1, 1'b0, f3, addr, 32'h0, 5'd9, 1'b1);
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            idle_inputs();
            if (wb_valid_o) begin
                lat = i;
                break;
            end
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        check({tag, "_lat"}, lat, 3);
        check({tag, "_data"}, wb_data_o, exp);
        check({tag, "_rw"}, wb_reg_write_o, 1'b1);
    endtask

    task automatic run_fault(input string tag, input logic rd_en, input logic wr_en,
                             input logic [2:0] f3, input logic [31:0] addr);
        @(negedge clk_i);
        drive(rd_en, wr_en, f3, addr, 32'h0, 5'd3, 1'b1);
        @(negedge clk_i);
        idle_inputs();
        check({tag, "_req"}, dmem_req_o, 1'b0);
        check({tag, "_stall"}, stall_o, 1'b0);
        check({tag, "_wbv"}, wb_valid_o, 1'b1);
        check({tag, "_fault"}, lsu_fault_o, 1'b1);
        check({tag, "_rw"}, wb_reg_write_o, 1'b0);
        check({tag, "_fwdrw"}, fwd_reg_write_o, 1'b0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        valid_i       = 1'b0;
        alu_result_i  = '0;
        w_ram_data_i  = '0;
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        funct3_i      = '0;
        rd_i          = '0;
        reg_write_i   = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;

        repeat (2) @(negedge clk_i);
        check("rst_stall", stall_o, 1'b0);
        check("rst_req", dmem_req_o, 1'b0);
        check("rst_we", dmem_we_o, 1'b0);
        check("rst_be", dmem_be_o, 4'b0000);
        check("rst_wbv", wb_valid_o, 1'b0);
        check("rst_fault", lsu_fault_o, 1'b0);
        check("rst_fwdrw", fwd_reg_write_o, 1'b0);
        check("rst_addr", dmem_addr_o, 32'h0);
        check("rst_wbdata", wb_data_o, 32'h0);
        rst_ni = 1'b1;

        // ALU ops back to back
        @(negedge clk_i);
        drive(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        check("alu_stall0", stall_o, 1'b0);
        @(negedge clk_i);
        check("alu_wbv", wb_valid_o, 1'b1);
        check("alu_data", wb_data_o, 32'h1234);
        check("alu_rd", wb_rd_o, 5'd5);
        check("alu_rw", wb_reg_write_o, 1'b1);
        check("alu_stall1", stall_o, 1'b0);
        check("alu_fwdrw", fwd_reg_write_o, 1'b1);
        check("alu_fwddata", fwd_data_o, 32'h1234);
        drive(1'b0, 1'b0, 3'b000, 32'h5678, 32'h0, 5'd6, 1'b1);
        @(negedge clk_i);
        idle_inputs();
        check("alu2_wbv", wb_valid_o, 1'b1);
        check("alu2_data", wb_data_o, 32'h5678);
        check("alu2_rd", wb_rd_o, 5'd6);
        @(negedge clk_i);
        check("bubble_wbv", wb_valid_o, 1'b0);
        check("bubble_fwdrw", fwd_reg_write_o, 1'b0);

        // SB 0x103, granted in the first REQ cycle
        drive(1'b0, 1'b1, 3'b000, 32'h103, 32'hAB, 5'd0, 1'b0);
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        check("sb_req", dmem_req_o, 1'b1);
        check("sb_stall", stall_o, 1'b1);
        check("sb_we", dmem_we_o, 1'b1);
        check("sb_addr", dmem_addr_o, 32'h100);
        check("sb_be", dmem_be_o, 4'b1000);
        check("sb_wdata", dmem_wdata_o, 32'hABABABAB);
        check("sb_wbv_early", wb_valid_o, 1'b0);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        check("sb_wbv", wb_valid_o, 1'b1);
        check("sb_rw", wb_reg_write_o, 1'b0);
        check("sb_stall_end", stall_o, 1'b0);
        check("sb_req_end", dmem_req_o, 1'b0);
        // accepted while the store's writeback pulse is up
        drive(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd8, 1'b1);
        @(negedge clk_i);
        idle_inputs();
        check("b2b_wbv", wb_valid_o, 1'b1);
        check("b2b_data", wb_data_o, 32'h77);

        // LH 0x102: gnt low for 3 REQ cycles, rvalid in the 2nd WAIT cycle
        @(negedge clk_i);
        drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            idle_inputs();
            check("lh_req", dmem_req_o, 1'b1);
            check("lh_stall", stall_o, 1'b1);
            check("lh_addr", dmem_addr_o, 32'h100);
            check("lh_be", dmem_be_o, 4'b1100);
            if (i == 3) dmem_gnt_i = 1'b1;
        end
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        check("lh_wait_req", dmem_req_o, 1'b0);
        check("lh_wait_stall", stall_o, 1'b1);
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("lh_wait2_stall", stall_o, 1'b1);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h8001_0000;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        check("lh_wbv", wb_valid_o, 1'b1);
        check("lh_data", wb_data_o, 32'hFFFF8001);
        check("lh_rd", wb_rd_o, 5'd7);
        check("lh_stall_end", stall_o, 1'b0);

        run_load("lbu", 3'b100, 32'h1, 32'h0000_F000, 32'h0000_00F0);
        run_load("lb",  3'b000, 32'h1, 32'h0000_F000, 32'hFFFF_FFF0);
        run_load("lw",  3'b010, 32'h4, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_load("lhu", 3'b101, 32'h2, 32'h8001_0000, 32'h0000_8001);

        run_fault("lw_mis", 1'b1, 1'b0, 3'b010, 32'h2);
        run_fault("ld_f3",  1'b1, 1'b0, 3'b011, 32'h0);
        run_fault("sh_mis", 1'b0, 1'b1, 3'b001, 32'h1);
        run_fault("sb_f3",  1'b0, 1'b1, 3'b100, 32'h0);
        run_fault("rdwr",   1'b1, 1'b1, 3'b000, 32'h0);

        // reset while in REQ drops the request at once
        @(negedge clk_i);
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd4, 1'b1);
        @(negedge clk_i);
        idle_inputs();
        check("rreq_req", dmem_req_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("rreq_req_drop", dmem_req_o, 1'b0);
        check("rreq_stall", stall_o, 1'b0);
        @(negedge clk_i);
        rst_ni     = 1'b1;
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        check("rreq_gnt_ign", stall_o, 1'b0);

        // reset while in WAIT; stray rvalid afterwards is ignored
        @(negedge clk_i);
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd4, 1'b1);
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        check("rwait_stall", stall_o, 1'b1);
        check("rwait_req", dmem_req_o, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("rwait_stall_rst", stall_o, 1'b0);
        check("rwait_req_rst", dmem_req_o, 1'b0);
        check("rwait_wbv_rst", wb_valid_o, 1'b0);
        @(negedge clk_i);
        rst_ni        = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        check("stray_wbv1", wb_valid_o, 1'b0);
        @(negedge clk_i);
        check("stray_wbv2", wb_valid_o, 1'b0);
        check("stray_stall", stall_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
